// File: rtl/led_pattern_sequencer.sv
// 8-LED display controller: prescaled step counter, debounced mode button and
// four display patterns (binary, Gray, bouncing scan, PWM breathe).
module led_pattern_sequencer #(
    parameter int PRESCALE_BITS = 24,
    parameter int DB_BITS       = 20,
    parameter int AUTO_STEPS    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       auto_en,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    typedef enum logic [1:0] {
        MODE_BIN     = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam logic [PRESCALE_BITS-1:0] PRESC_MAX = '1;
    localparam logic [DB_BITS-1:0]       DB_MAX    = '1;
    localparam logic [7:0]               AUTO_LAST = 8'(AUTO_STEPS - 1);

    logic [PRESCALE_BITS-1:0] presc_q;
    logic [7:0]               step_q;
    logic [2:0]               pos_q;
    logic                     dir_down_q;
    logic                     sync1_q;
    logic                     sync2_q;
    logic                     stable_q;
    logic [DB_BITS-1:0]       db_cnt_q;
    logic [7:0]               auto_cnt_q;
    mode_e                    mode_q;
    logic [7:0]               led_q;

    logic       tick_w;
    logic       db_accept;
    logic       press;
    logic       auto_adv;
    logic       advance;
    logic [7:0] duty;
    logic [7:0] led_d;

    assign tick_w    = (presc_q == PRESC_MAX);
    assign db_accept = (sync2_q != stable_q) && (db_cnt_q == DB_MAX);
    assign press     = db_accept && sync2_q;
    assign auto_adv  = auto_en && tick_w && (auto_cnt_q == AUTO_LAST);
    // A press landing on the auto-advance tick still moves the mode by one.
    assign advance   = press || auto_adv;
    assign duty      = step_q[7] ? ~{step_q[6:0], 1'b0} : {step_q[6:0], 1'b0};

    always_comb begin
        // NOTE: default assignment first so every path drives led_d and no latch is inferred.
        led_d = '0;
        case (mode_q)
            MODE_BIN:     led_d = step_q;
            MODE_GRAY:    led_d = step_q ^ (step_q >> 1);
            MODE_SCAN:    led_d = 8'b1 << pos_q;
            MODE_BREATHE: led_d = (presc_q[7:0] < duty) ? 8'hFF : 8'h00;
            default:      led_d = '0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            step_q     <= '0;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            stable_q   <= 1'b0;
            db_cnt_q   <= '0;
            auto_cnt_q <= '0;
            mode_q     <= MODE_BIN;
            led_q      <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (tick_w) step_q <= step_q + 8'd1;

            sync1_q <= btn;
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
                db_cnt_q <= '0;
            end else if (db_accept) begin
                stable_q <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end

            if (!auto_en || advance) auto_cnt_q <= '0;
            else if (tick_w)         auto_cnt_q <= auto_cnt_q + 8'd1;

            if (advance) begin
                mode_q     <= mode_e'(mode_q + 2'd1);
                pos_q      <= '0;
                dir_down_q <= 1'b0;
            end else if (tick_w && mode_q == MODE_SCAN) begin
                // Turn around on the end position so each end is lit for one step only.
                if (!dir_down_q) begin
                    if (pos_q == 3'd7) begin
                        dir_down_q <= 1'b1;
                        pos_q      <= 3'd6;
                    end else begin
                        pos_q <= pos_q + 3'd1;
                    end
                end else begin
                    if (pos_q == 3'd0) begin
                        dir_down_q <= 1'b0;
                        pos_q      <= 3'd1;
                    end else begin
                        pos_q <= pos_q - 3'd1;
                    end
                end
            end

            led_q <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign tick = tick_w;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: a cycle-count based reference model is compared
// against the DUT every cycle, plus fixed expectations from hand-worked scenarios.
module tb_led_pattern_sequencer;

    localparam int PB  = 9;
    localparam int DB  = 3;
    localparam int AS  = 4;
    localparam int PER = 1 << PB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn     = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    led_pattern_sequencer #(
        .PRESCALE_BITS(PB),
        .DB_BITS      (DB),
        .AUTO_STEPS   (AS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn),
        .auto_en(auto_en),
        .led    (led),
        .mode   (mode),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything derived from the number of clocks since reset.
    int         m_n;
    int         m_run;
    int         m_mode;
    int         m_auto;
    int         m_scan_k;
    bit         m_b1;
    bit         m_b2;
    bit         m_stable;
    logic [7:0] m_led;

    function automatic logic [7:0] exp_led(input int md, input int stp, input int k, input int presc);
        int m;
        int x;
        int duty;
        case (md)
            0: exp_led = 8'(stp);
            1: exp_led = 8'(stp ^ (stp / 2));
            2: begin
                m = k % 14;
                exp_led = 8'(1 << ((m <= 7) ? m : 14 - m));
            end
            default: begin
                x    = (stp % 128) * 2;
                duty = (stp >= 128) ? 255 - x : x;
                exp_led = ((presc % 256) < duty) ? 8'hFF : 8'h00;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_n = 0; m_run = 0; m_mode = 0; m_auto = 0; m_scan_k = 0;
        m_b1 = 0; m_b2 = 0; m_stable = 0; m_led = 8'h00;
    endtask

    task automatic model_step();
        int         presc;
        int         stp;
        bit         tk;
        bit         prs;
        bit         adv;
        logic [7:0] nled;
        presc = m_n % PER;
        stp   = (m_n / PER) % 256;
        tk    = (presc == PER - 1);
        nled  = exp_led(m_mode, stp, m_scan_k, presc);
        prs   = 0;
        if (m_b2 != m_stable) begin
            m_run++;
            if (m_run == (1 << DB)) begin
                m_stable = m_b2;
                m_run    = 0;
                prs      = m_b2;
            end
        end else begin
            m_run = 0;
        end
        adv = prs || (auto_en && tk && m_auto == AS - 1);
        if (!auto_en || adv) m_auto = 0;
        else if (tk)         m_auto++;
        if (adv) begin
            m_mode   = (m_mode + 1) % 4;
            m_scan_k = 0;
        end else if (tk && m_mode == 2) begin
            m_scan_k++;
        end
        m_n++;
        m_b2  = m_b1;
        m_b1  = btn;
        m_led = nled;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cycle", 32'({tick, mode, led}),
                  32'({((m_n % PER) == PER - 1) ? 1'b1 : 1'b0, 2'(m_mode), m_led}));
        end
    end

    task automatic wait_presc(input int p);
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (m_n % PER == p) return;
        end
        check("wait_presc_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_step(input int stp, input int p);
        for (int i = 0; i < 150000; i++) begin
            @(negedge clk);
            if ((m_n / PER) % 256 == stp && m_n % PER == p) return;
        end
        check("wait_step_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_press();
        btn = 1'b1;
        repeat (14) @(negedge clk);
        btn = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        int         cnt;
        int         on_cnt;
        logic [7:0] scan_seq [16];
        scan_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // Reset state, first tick position and binary count.
        repeat (3) @(negedge clk);
        check("reset_led", 32'(led), 32'h00);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        cnt = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (tick) begin
                cnt = i;
                break;
            end
        end
        check("first_tick_cycle", 32'(cnt), 32'd511);
        @(negedge clk);
        check("tick_width", 32'(tick), 32'd0);
        wait_step(5, 10);
        check("bin_step5", 32'(led), 32'h05);

        // Press latency, single advance, Gray pattern.
        btn = 1'b1;
        cnt = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mode == 2'd1 && cnt < 0) cnt = i;
        end
        btn = 1'b0;
        check("press_latency_ok", 32'((cnt >= 1 && cnt <= 12) ? 1 : 0), 32'd1);
        repeat (20) @(negedge clk);
        check("press_once", 32'(mode), 32'd1);
        wait_step(8'h0B, 10);
        check("gray_0B", 32'(led), 32'h0E);

        // Debounce: glitch ignored, bounce gives one press, four presses wrap.
        btn = 1'b1;
        repeat (5) @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_ignored", 32'(mode), 32'd1);
        for (int b = 0; b < 3; b++) begin
            btn = 1'b1;
            repeat (3) @(negedge clk);
            btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        do_press();
        check("bounce_single", 32'(mode), 32'd2);
        do_press();
        do_press();
        check("four_presses_wrap", 32'(mode), 32'd0);

        // Breathe at step 0x20: duty 0x40.
        repeat (3) do_press();
        check("enter_breathe", 32'(mode), 32'd3);
        wait_step(8'h20, 10);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led == 8'hFF) on_cnt++;
        end
        check("breathe_20_on", 32'(on_cnt), 32'd64);

        // Scan sequence and restart on re-entry.
        wait_presc(20);
        repeat (3) do_press();
        check("enter_scan", 32'(mode), 32'd2);
        check("scan_0", 32'(led), 32'(scan_seq[0]));
        for (int i = 1; i < 16; i++) begin
            wait_presc(20);
            check($sformatf("scan_%0d", i), 32'(led), 32'(scan_seq[i]));
        end
        repeat (4) do_press();
        check("reenter_scan", 32'(mode), 32'd2);
        check("reenter_led0", 32'(led), 32'h01);
        wait_presc(20);
        check("reenter_led1", 32'(led), 32'h02);

        // Auto-advance every 4 ticks.
        wait_presc(20);
        auto_en = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            wait_presc(20);
            if (t == 3) check("auto_hold", 32'(mode), 32'd2);
            if (t == 4) check("auto_adv1", 32'(mode), 32'd3);
            if (t == 8) check("auto_adv2", 32'(mode), 32'd0);
        end
        repeat (3) wait_presc(20);
        // Stable button rises exactly on the tick that also auto-advances.
        wait_presc(PER - 10);
        btn = 1'b1;
        repeat (20) @(negedge clk);
        btn = 1'b0;
        check("coincide_single", 32'(mode), 32'd1);
        wait_presc(20);
        repeat (3) wait_presc(20);
        check("coincide_restart_hold", 32'(mode), 32'd1);
        wait_presc(20);
        check("coincide_restart_adv", 32'(mode), 32'd2);
        repeat (2) wait_presc(20);
        do_press();
        check("press_mid_count", 32'(mode), 32'd3);
        repeat (3) wait_presc(20);
        check("press_clears_auto_hold", 32'(mode), 32'd3);
        wait_presc(20);
        check("press_clears_auto_adv", 32'(mode), 32'd0);

        // Random button and auto_en activity; the model checks every cycle.
        for (int r = 0; r < 120; r++) begin
            btn     = 1'($urandom_range(0, 1));
            auto_en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        btn     = 1'b0;
        auto_en = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (m_mode != 3) do_press();
        end
        check("breathe_again", 32'(mode), 32'd3);

        // Breathe at step 0xA0: duty 0xBF.
        wait_step(8'hA0, 10);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led == 8'hFF) on_cnt++;
        end
        check("breathe_A0_on", 32'(on_cnt), 32'd191);

        // Asynchronous reset without a clock edge.
        check("pre_reset_led", 32'(led), 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_led", 32'(led), 32'h00);
        check("async_mode", 32'(mode), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
